// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: memop bit positions,
// access-size codes and FSM state constants.
package dmem_ctrl_pkg;

  // One-hot memop vector width and bit positions
  localparam int unsigned MMOP8   = 8;
  localparam int unsigned MOP_LB  = 0;
  localparam int unsigned MOP_LBU = 1;
  localparam int unsigned MOP_LH  = 2;
  localparam int unsigned MOP_LHU = 3;
  localparam int unsigned MOP_LW  = 4;
  localparam int unsigned MOP_SB  = 5;
  localparam int unsigned MOP_SH  = 6;
  localparam int unsigned MOP_SW  = 7;

  // data_sram_size encodings
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Access FSM states
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StCancel = 2'd3;

endpackage

// File: rtl/dmem_fmt.sv
// Combinational access formatting: alignment check, size code, byte strobes and
// lane-replicated store data derived from the one-hot memop and address.
module dmem_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [MMOP8-1:0] memop,
  input  logic [1:0]       addr_low,
  input  logic [31:0]      src_data,
  output logic             is_load,
  output logic             is_store,
  output logic             misalign,
  output logic [1:0]       size,
  output logic [3:0]       wstrb,
  output logic [31:0]      wdata
);

  logic byte_op;
  logic half_op;
  logic word_op;

  // Decode width class, alignment, and store lane formatting
  always_comb begin
    byte_op  = memop[MOP_LB] | memop[MOP_LBU] | memop[MOP_SB];
    half_op  = memop[MOP_LH] | memop[MOP_LHU] | memop[MOP_SH];
    word_op  = memop[MOP_LW] | memop[MOP_SW];
    is_load  = memop[MOP_LB] | memop[MOP_LBU] | memop[MOP_LH] | memop[MOP_LHU] | memop[MOP_LW];
    is_store = memop[MOP_SB] | memop[MOP_SH] | memop[MOP_SW];
    misalign = (half_op & addr_low[0]) | (word_op & (addr_low != 2'b00));

    size = SZ_B;
    if (half_op) size = SZ_H;
    if (word_op) size = SZ_W;

    wstrb = 4'b0000;
    wdata = 32'h0;
    if (memop[MOP_SB]) begin
      wstrb = 4'b0001 << addr_low;
      wdata = {4{src_data[7:0]}};
    end else if (memop[MOP_SH]) begin
      wstrb = addr_low[1] ? 4'b1100 : 4'b0011;
      wdata = {2{src_data[15:0]}};
    end else if (memop[MOP_SW]) begin
      wstrb = 4'b1111;
      wdata = src_data;
    end
    // byte_op only affects the size default; keep it referenced explicitly
    if (byte_op) size = SZ_B;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-SRAM access controller between EX and MEM. Issues at most one access per
// instruction over req/addr_ok/data_ok, holds EX until it completes, and registers
// read data plus address/exception side info alongside the EX/MEM register.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MMOP8-1:0]  ex_memop_i,
  input  logic [ADDR_W-1:0] ex_memaddr_i,
  input  logic [DATA_W-1:0] ex_memwdata_i,
  input  logic              ex_valid_i,
  input  logic              pipe_stall_i,
  input  logic              pipe_flush_i,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic [DATA_W-1:0] mem_memdata_o,
  output logic [1:0]        mem_memaddr_low_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              dmem_stall_o
);

  logic              is_load;
  logic              is_store;
  logic              misalign;
  logic [1:0]        fmt_size;
  logic [3:0]        fmt_wstrb;
  logic [DATA_W-1:0] fmt_wdata;

  dmem_fmt u_fmt (
    .memop    (ex_memop_i),
    .addr_low (ex_memaddr_i[1:0]),
    .src_data (ex_memwdata_i),
    .is_load  (is_load),
    .is_store (is_store),
    .misalign (misalign),
    .size     (fmt_size),
    .wstrb    (fmt_wstrb),
    .wdata    (fmt_wdata)
  );

  logic [1:0]        state_q, state_d;
  logic              done_q;
  logic              start;
  logic              req_wr_q;
  logic [1:0]        req_size_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [3:0]        req_wstrb_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [DATA_W-1:0] memdata_q;
  logic [1:0]        addr_low_q;
  logic              adel_q;
  logic              ades_q;
  logic [ADDR_W-1:0] badvaddr_q;
  logic              ex_adel;
  logic              ex_ades;

  // done_q blocks a replay when the access finished but EX is held downstream
  assign start   = ex_valid_i & (|ex_memop_i) & ~misalign & ~pipe_flush_i & ~done_q & ~rst;
  assign ex_adel = ex_valid_i & is_load & misalign;
  assign ex_ades = ex_valid_i & is_store & misalign;

  // Next-state logic for the access FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = data_sram_addr_ok ? StWait : StReq;
      end
      StReq: begin
        // An accept coinciding with a flush still owes us a data_ok
        if (data_sram_addr_ok)  state_d = pipe_flush_i ? StCancel : StWait;
        else if (pipe_flush_i)  state_d = StIdle;
      end
      StWait: begin
        if (data_sram_data_ok)  state_d = StIdle;
        else if (pipe_flush_i)  state_d = StCancel;
      end
      StCancel: begin
        if (data_sram_data_ok)  state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM request outputs and EX stall; request fields are zero when req is low
  always_comb begin
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'b00;
    data_sram_addr  = '0;
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = '0;
    dmem_stall_o    = 1'b0;
    case (state_q)
      StIdle: begin
        data_sram_req = start;
        dmem_stall_o  = start;
        if (start) begin
          data_sram_wr    = is_store;
          data_sram_size  = fmt_size;
          data_sram_addr  = ex_memaddr_i;
          data_sram_wstrb = fmt_wstrb;
          data_sram_wdata = fmt_wdata;
        end
      end
      StReq: begin
        data_sram_req   = 1'b1;
        data_sram_wr    = req_wr_q;
        data_sram_size  = req_size_q;
        data_sram_addr  = req_addr_q;
        data_sram_wstrb = req_wstrb_q;
        data_sram_wdata = req_wdata_q;
        dmem_stall_o    = 1'b1;
      end
      StWait:   dmem_stall_o = ~data_sram_data_ok;
      StCancel: dmem_stall_o = start;
      default:  dmem_stall_o = 1'b0;
    endcase
  end

  // FSM state, the request copy captured on issue, completion flag and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'b00;
      req_addr_q  <= '0;
      req_wstrb_q <= 4'b0000;
      req_wdata_q <= '0;
      memdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        req_wr_q    <= is_store;
        req_size_q  <= fmt_size;
        req_addr_q  <= ex_memaddr_i;
        req_wstrb_q <= fmt_wstrb;
        req_wdata_q <= fmt_wdata;
      end
      if (pipe_flush_i || !pipe_stall_i) begin
        done_q <= 1'b0;
      end else if (state_q == StWait && data_sram_data_ok) begin
        done_q <= 1'b1;
      end
      if (state_q == StWait && data_sram_data_ok) begin
        memdata_q <= data_sram_rdata;
      end
    end
  end

  // EX/MEM side info: load on advance, bubble while EX is held by this block
  always_ff @(posedge clk) begin
    if (rst || pipe_flush_i) begin
      addr_low_q <= 2'b00;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      badvaddr_q <= '0;
    end else if (!pipe_stall_i) begin
      if (dmem_stall_o) begin
        addr_low_q <= 2'b00;
        adel_q     <= 1'b0;
        ades_q     <= 1'b0;
        badvaddr_q <= '0;
      end else begin
        addr_low_q <= ex_memaddr_i[1:0];
        adel_q     <= ex_adel;
        ades_q     <= ex_ades;
        badvaddr_q <= (ex_adel | ex_ades) ? ex_memaddr_i : '0;
      end
    end
  end

  assign mem_memdata_o     = memdata_q;
  assign mem_memaddr_low_o = addr_low_q;
  assign adel_o            = adel_q;
  assign ades_o            = ades_q;
  assign badvaddr_o        = badvaddr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios followed by randomized
// traffic against a transaction-level reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_memop_i;
  logic [31:0] ex_memaddr_i;
  logic [31:0] ex_memwdata_i;
  logic        ex_valid_i;
  logic        pipe_stall_i;
  logic        pipe_flush_i;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [31:0] mem_memdata_o;
  logic [1:0]  mem_memaddr_low_o;
  logic        adel_o;
  logic        ades_o;
  logic [31:0] badvaddr_o;
  logic        dmem_stall_o;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .ex_memop_i        (ex_memop_i),
    .ex_memaddr_i      (ex_memaddr_i),
    .ex_memwdata_i     (ex_memwdata_i),
    .ex_valid_i        (ex_valid_i),
    .pipe_stall_i      (pipe_stall_i),
    .pipe_flush_i      (pipe_flush_i),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_memdata_o     (mem_memdata_o),
    .mem_memaddr_low_o (mem_memaddr_low_o),
    .adel_o            (adel_o),
    .ades_o            (ades_o),
    .badvaddr_o        (badvaddr_o),
    .dmem_stall_o      (dmem_stall_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] wd);
    ex_valid_i    = v;
    ex_memop_i    = op;
    ex_memaddr_i  = a;
    ex_memwdata_i = wd;
  endtask

  // Reference helpers: access width in bytes from the memop bit layout
  function automatic int nbytes(input logic [7:0] op);
    if (op[0] | op[1] | op[5]) return 1;
    if (op[2] | op[3] | op[6]) return 2;
    if (op[4] | op[7])         return 4;
    return 0;
  endfunction

  function automatic bit is_st(input logic [7:0] op);
    return op[5] | op[6] | op[7];
  endfunction

  function automatic logic [1:0] size_code(input int n);
    return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [7:0] op, input logic [1:0] a);
    int n = nbytes(op);
    if (!is_st(op)) return 4'b0000;
    return 4'(((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] rep_data(input logic [31:0] src, input int n);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = src[8*(i % n) +: 8];
    return r;
  endfunction

  // Random-phase model state
  logic [7:0]  m_op;
  logic [31:0] m_addr, m_wd;
  logic        m_v;
  bit          need_new, accepted, done_m, pend, mis, access, e_req, e_stall;
  int          cnt, nb, k;
  logic [31:0] e_memdata, e_badv;
  logic [1:0]  e_low;
  logic        e_adel, e_ades;

  initial begin
    rst = 1'b1;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    pipe_stall_i = 1'b0;
    pipe_flush_i = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;

    // Reset: a valid store in EX must not leak through while rst is high
    repeat (2) tick();
    set_ex(1'b1, 8'h80, 32'h0000_0100, 32'h1234_5678);
    #1;
    check("rst_req",   32'(data_sram_req), 32'd0);
    check("rst_stall", 32'(dmem_stall_o), 32'd0);
    check("rst_addr",  data_sram_addr, 32'd0);
    check("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
    check("rst_wdata", data_sram_wdata, 32'd0);
    check("rst_mdata", mem_memdata_o, 32'd0);
    check("rst_low",   32'(mem_memaddr_low_o), 32'd0);
    check("rst_adel",  32'(adel_o), 32'd0);
    check("rst_ades",  32'(ades_o), 32'd0);
    check("rst_badv",  badvaddr_o, 32'd0);
    tick();
    rst = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);

    // lw, zero-wait SRAM
    tick();
    set_ex(1'b1, 8'h10, 32'h0000_1004, 32'h0);
    data_sram_addr_ok = 1'b1;
    #1;
    check("lw_req",   32'(data_sram_req), 32'd1);
    check("lw_size",  32'(data_sram_size), 32'd2);
    check("lw_wstrb", 32'(data_sram_wstrb), 32'd0);
    check("lw_wr",    32'(data_sram_wr), 32'd0);
    check("lw_addr",  data_sram_addr, 32'h0000_1004);
    check("lw_stall", 32'(dmem_stall_o), 32'd1);
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("lw_req2",   32'(data_sram_req), 32'd0);
    check("lw_stall2", 32'(dmem_stall_o), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    #1;
    check("lw_mdata", mem_memdata_o, 32'hDEAD_BEEF);
    check("lw_low",   32'(mem_memaddr_low_o), 32'd0);

    // sb at byte 3
    set_ex(1'b1, 8'h20, 32'h0000_2003, 32'h0000_00A5);
    data_sram_addr_ok = 1'b1;
    #1;
    check("sb_req",   32'(data_sram_req), 32'd1);
    check("sb_wstrb", 32'(data_sram_wstrb), 32'h8);
    check("sb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
    check("sb_size",  32'(data_sram_size), 32'd0);
    check("sb_wr",    32'(data_sram_wr), 32'd1);
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    #1;
    check("sb_stall", 32'(dmem_stall_o), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    #1;
    check("sb_low", 32'(mem_memaddr_low_o), 32'd3);

    // sh with addr_ok delayed three cycles; EX inputs perturbed to prove latching
    tick();
    set_ex(1'b1, 8'h40, 32'h0000_3002, 32'h0000_BEEF);
    #1;
    check("sh_req0",   32'(data_sram_req), 32'd1);
    check("sh_addr0",  data_sram_addr, 32'h0000_3002);
    check("sh_wstrb0", 32'(data_sram_wstrb), 32'hC);
    check("sh_wdata0", data_sram_wdata, 32'hBEEF_BEEF);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) begin
        ex_memaddr_i  = 32'h0000_5551;
        ex_memwdata_i = 32'h0;
      end else begin
        set_ex(1'b1, 8'h40, 32'h0000_3002, 32'h0000_BEEF);
        data_sram_addr_ok = 1'b1;
      end
      #1;
      check("sh_req",   32'(data_sram_req), 32'd1);
      check("sh_addr",  data_sram_addr, 32'h0000_3002);
      check("sh_wstrb", 32'(data_sram_wstrb), 32'hC);
      check("sh_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      check("sh_stall", 32'(dmem_stall_o), 32'd1);
    end
    tick();
    data_sram_addr_ok = 1'b0;
    #1;
    check("sh_req_w",   32'(data_sram_req), 32'd0);
    check("sh_stall_w", 32'(dmem_stall_o), 32'd1);
    tick();
    data_sram_data_ok = 1'b1;
    #1;
    check("sh_stall_d", 32'(dmem_stall_o), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    #1;
    check("sh_low", 32'(mem_memaddr_low_o), 32'd2);

    // Misaligned lh then misaligned sw
    tick();
    set_ex(1'b1, 8'h04, 32'h0000_4001, 32'h0);
    #1;
    check("mis_lh_req",   32'(data_sram_req), 32'd0);
    check("mis_lh_stall", 32'(dmem_stall_o), 32'd0);
    tick();
    set_ex(1'b1, 8'h80, 32'h0000_4402, 32'h0);
    #1;
    check("mis_adel",     32'(adel_o), 32'd1);
    check("mis_ades0",    32'(ades_o), 32'd0);
    check("mis_badv",     badvaddr_o, 32'h0000_4001);
    check("mis_sw_req",   32'(data_sram_req), 32'd0);
    check("mis_sw_stall", 32'(dmem_stall_o), 32'd0);
    tick();
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    #1;
    check("mis_adel0", 32'(adel_o), 32'd0);
    check("mis_ades",  32'(ades_o), 32'd1);
    check("mis_badv2", badvaddr_o, 32'h0000_4402);
    tick();
    #1;
    check("mis_ades_clr", 32'(ades_o), 32'd0);
    check("mis_badv_clr", badvaddr_o, 32'd0);

    // Flush clears EX/MEM side info even for a misaligned op
    set_ex(1'b1, 8'h10, 32'h0000_5003, 32'h0);
    pipe_flush_i = 1'b1;
    tick();
    pipe_flush_i = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    #1;
    check("fl_adel", 32'(adel_o), 32'd0);
    check("fl_badv", badvaddr_o, 32'd0);

    // Flush in WAIT: stale data_ok dropped, next req only after it
    set_ex(1'b1, 8'h10, 32'h0000_5000, 32'h0);
    data_sram_addr_ok = 1'b1;
    #1;
    check("fw_req", 32'(data_sram_req), 32'd1);
    tick();
    data_sram_addr_ok = 1'b0;
    pipe_flush_i = 1'b1;
    #1;
    check("fw_stall", 32'(dmem_stall_o), 32'd1);
    tick();
    pipe_flush_i = 1'b0;
    set_ex(1'b1, 8'h10, 32'h0000_6008, 32'h0);
    #1;
    check("fc_req",   32'(data_sram_req), 32'd0);
    check("fc_stall", 32'(dmem_stall_o), 32'd1);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    check("fc_req_d",   32'(data_sram_req), 32'd0);
    check("fc_stall_d", 32'(dmem_stall_o), 32'd1);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_addr_ok = 1'b1;
    #1;
    check("fc_mdata", mem_memdata_o, 32'hDEAD_BEEF);
    check("fn_req",   32'(data_sram_req), 32'd1);
    check("fn_addr",  data_sram_addr, 32'h0000_6008);
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    #1;
    check("fn_stall", 32'(dmem_stall_o), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);
    #1;
    check("fn_mdata", mem_memdata_o, 32'h2222_2222);

    // Reset while in REQ
    set_ex(1'b1, 8'h80, 32'h0000_7000, 32'h0000_0001);
    #1;
    check("rr_req", 32'(data_sram_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    #1;
    check("rr_req0",   32'(data_sram_req), 32'd0);
    check("rr_stall",  32'(dmem_stall_o), 32'd0);
    check("rr_wr",     32'(data_sram_wr), 32'd0);
    check("rr_addr",   data_sram_addr, 32'd0);
    check("rr_wstrb",  32'(data_sram_wstrb), 32'd0);
    check("rr_wdata",  data_sram_wdata, 32'd0);
    check("rr_mdata",  mem_memdata_o, 32'd0);
    check("rr_low",    32'(mem_memaddr_low_o), 32'd0);
    tick();
    rst = 1'b0;
    set_ex(1'b0, 8'h00, 32'h0, 32'h0);

    // Randomized traffic against the reference model
    need_new  = 1'b1;
    accepted  = 1'b0;
    done_m    = 1'b0;
    pend      = 1'b0;
    cnt       = 0;
    e_memdata = 32'h0;
    e_badv    = 32'h0;
    e_low     = 2'b00;
    e_adel    = 1'b0;
    e_ades    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      check("r_mdata", mem_memdata_o, e_memdata);
      check("r_low",   32'(mem_memaddr_low_o), 32'(e_low));
      check("r_adel",  32'(adel_o), 32'(e_adel));
      check("r_ades",  32'(ades_o), 32'(e_ades));
      check("r_badv",  badvaddr_o, e_badv);
      if (need_new) begin
        m_v  = ($urandom % 5) != 0;
        k    = int'($urandom % 9);
        m_op = (k < 8) ? 8'(1 << k) : 8'h00;
        m_addr = $urandom;
        m_wd   = $urandom;
        need_new = 1'b0;
        accepted = 1'b0;
        done_m   = 1'b0;
      end
      set_ex(m_v, m_op, m_addr, m_wd);
      pipe_stall_i      = ($urandom % 4) == 0;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata   = $urandom;
          pend = 1'b0;
        end
      end
      nb      = nbytes(m_op);
      mis     = (nb > 0) && ((int'(m_addr[1:0]) % nb) != 0);
      access  = m_v && (nb > 0) && !mis;
      e_req   = access && !accepted;
      e_stall = access && !done_m && !data_sram_data_ok;
      #1;
      check("r_req",   32'(data_sram_req), 32'(e_req));
      check("r_stall", 32'(dmem_stall_o), 32'(e_stall));
      if (e_req) begin
        check("r_addr",  data_sram_addr, m_addr);
        check("r_wr",    32'(data_sram_wr), 32'(is_st(m_op)));
        check("r_size",  32'(data_sram_size), 32'(size_code(nb)));
        check("r_wstrb", 32'(data_sram_wstrb), 32'(exp_wstrb(m_op, m_addr[1:0])));
        if (is_st(m_op)) check("r_wdata", data_sram_wdata, rep_data(m_wd, nb));
        data_sram_addr_ok = ($urandom % 2) == 0;
      end
      #1;
      if (e_req && data_sram_addr_ok) begin
        accepted = 1'b1;
        pend     = 1'b1;
        cnt      = int'($urandom_range(1, 3));
      end
      if (data_sram_data_ok) begin
        e_memdata = data_sram_rdata;
        done_m    = 1'b1;
      end
      if (!pipe_stall_i) begin
        if (e_stall) begin
          e_low  = 2'b00;
          e_adel = 1'b0;
          e_ades = 1'b0;
          e_badv = 32'h0;
        end else begin
          e_low  = m_addr[1:0];
          e_adel = m_v && mis && !is_st(m_op);
          e_ades = m_v && mis && is_st(m_op);
          e_badv = (e_adel || e_ades) ? m_addr : 32'h0;
          need_new = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
